// File: rtl/pipe_fetch.sv
// pipe_fetch: Minisys IF stage with PC select, imem handshake and IF/ID feed.
// Optional misaligned-target halt enabled by defining FETCH_ALIGN_CHK_EN.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic        wir,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic        imem_timeout,
  output logic        misalign
);
`ifdef FETCH_ALIGN_CHK_EN
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, HALT} state_t;
  localparam logic [31:0] AMASK = 32'hFFFF_FFFF;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
`endif
  localparam logic [7:0] LIM = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, hold_q, hold_d, tgt_q, tgt_d, target, pc_inc, ld_pc;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d, redir, ld, del_f, del_h;

  assign redir  = |pcsource & ~stall;
  assign target = pcsource == 2'd1 ? bpc : pcsource == 2'd2 ? rpc : jpc;
  assign pc_inc = pc_q + 32'd4;
  assign del_f  = state_q == FETCH & ~stall & ~redir & imem_rdy;
  assign del_h  = state_q == HOLD & ~stall & ~redir;

  assign imem_req     = state_q == FETCH | state_q == DRAIN;
  assign imem_addr    = pc_q;
  assign wir          = state_q != IDLE & ~stall;
  assign ins          = del_f ? imem_rdata : del_h ? hold_q : 32'h0;
  assign pc4          = del_f | del_h ? pc_inc : 32'h0;
  assign pc           = pc_q;
  assign imem_timeout = tmo_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    tgt_d   = tgt_q;
    ld      = 1'b0;
    ld_pc   = target;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH:
        if (stall) begin
          if (imem_rdy) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redir) begin
          if (imem_rdy) ld = 1'b1;
          else begin
            tgt_d   = target;
            state_d = DRAIN;
          end
        end else if (imem_rdy) pc_d = pc_inc;
      HOLD:
        if (!stall) begin
          state_d = FETCH;
          if (redir) ld = 1'b1;
          else pc_d = pc_inc;
        end
      DRAIN: begin
        if (redir) tgt_d = target;
        if (imem_rdy) begin
          ld      = 1'b1;
          ld_pc   = redir ? target : tgt_q;
          state_d = FETCH;
        end
      end
      default: ;
    endcase
    if (ld) pc_d = ld_pc & AMASK;
    cnt_d = (!imem_req || imem_rdy) ? 8'd0 : cnt_q == LIM ? cnt_q : cnt_q + 8'd1;
    tmo_d = tmo_q | (cnt_d == LIM);
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic mis_q, mis_d, bad_ld;
  assign bad_ld   = (ld & |ld_pc[1:0]) | (state_q == IDLE & |pc_q[1:0]);
  assign mis_d    = mis_q | bad_ld;
  assign misalign = mis_q;
  always_ff @(posedge clk) begin
    if (!clrn) mis_q <= 1'b0;
    else mis_q <= mis_d;
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & AMASK;
      hold_q  <= 32'h0;
      tgt_q   <= 32'h0;
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
`ifdef FETCH_ALIGN_CHK_EN
      state_q <= bad_ld ? HALT : state_d;
`else
      state_q <= state_d;
`endif
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed checks of pipe_fetch with a zero-wait addr-as-data memory.
module tb_pipe_fetch;
  logic        clk = 1'b0, clrn = 1'b0, stall = 1'b0, imem_rdy = 1'b1;
  logic [1:0]  pcsource = 2'd0;
  logic [31:0] bpc = 32'h0, rpc = 32'h0, jpc = 32'h0;
  logic        imem_req, wir, imem_timeout, misalign;
  logic [31:0] imem_addr, imem_rdata, pc4, ins, pc;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr;

  pipe_fetch #(.RESET_PC(32'h100), .WAIT_LIMIT(255)) dut (
    .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_rdata(imem_rdata), .wir(wir), .pc4(pc4), .ins(ins), .pc(pc),
    .imem_timeout(imem_timeout), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic rq, input logic [31:0] ad,
                      input logic w, input logic [31:0] i, input logic [31:0] p);
    #2;
    chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, rq});
    if (rq) chk({tag, ".addr"}, imem_addr, ad);
    chk({tag, ".wir"}, {31'h0, wir}, {31'h0, w});
    chk({tag, ".ins"}, ins, i);
    chk({tag, ".pc4"}, pc4, p);
  endtask

  initial begin
    tick();
    look("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst.pc", pc, 32'h100);
    chk("rst.tmo", {31'h0, imem_timeout}, 32'h0);
    chk("rst.mis", {31'h0, misalign}, 32'h0);
    tick(); clrn = 1'b1;
    look("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick(); look("seq0", 1'b1, 32'h100, 1'b1, 32'h100, 32'h104);
    tick(); look("seq1", 1'b1, 32'h104, 1'b1, 32'h104, 32'h108);
    tick(); look("seq2", 1'b1, 32'h108, 1'b1, 32'h108, 32'h10C);
    tick(); pcsource = 2'd1; bpc = 32'h200;
    look("br.bub", 1'b1, 32'h10C, 1'b1, 32'h0, 32'h0);
    tick(); pcsource = 2'd0;
    look("br.tgt", 1'b1, 32'h200, 1'b1, 32'h200, 32'h204);
    tick(); pcsource = 2'd3; jpc = 32'h300; imem_rdy = 1'b0;
    look("dr.b1", 1'b1, 32'h204, 1'b1, 32'h0, 32'h0);
    tick(); pcsource = 2'd0;
    look("dr.b2", 1'b1, 32'h204, 1'b1, 32'h0, 32'h0);
    tick(); look("dr.b3", 1'b1, 32'h204, 1'b1, 32'h0, 32'h0);
    tick(); imem_rdy = 1'b1;
    look("dr.b4", 1'b1, 32'h204, 1'b1, 32'h0, 32'h0);
    tick(); look("dr.tgt", 1'b1, 32'h300, 1'b1, 32'h300, 32'h304);
    tick(); stall = 1'b1;
    look("st.cap", 1'b1, 32'h304, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); look("st.hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    end
    tick(); stall = 1'b0;
    look("st.rel", 1'b0, 32'h0, 1'b1, 32'h304, 32'h308);
    tick(); look("st.next", 1'b1, 32'h308, 1'b1, 32'h308, 32'h30C);
    tick(); pcsource = 2'd3; jpc = 32'hFFFF_FFFC;
    look("wr.bub", 1'b1, 32'h30C, 1'b1, 32'h0, 32'h0);
    tick(); pcsource = 2'd0;
    look("wr.top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0);
    tick(); pcsource = 2'd2; rpc = 32'h403;
    look("wr.zero", 1'b1, 32'h0, 1'b1, 32'h0, 32'h0);
    tick(); pcsource = 2'd0;
`ifdef FETCH_ALIGN_CHK_EN
    look("mis.halt", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    chk("mis.flag", {31'h0, misalign}, 32'h1);
    tick(); look("mis.stay", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
`else
    look("mis.off", 1'b1, 32'h400, 1'b1, 32'h400, 32'h404);
    chk("mis.flag", {31'h0, misalign}, 32'h0);
`endif
    tick(); clrn = 1'b0;
    tick(); clrn = 1'b1;
    #2;
    chk("rst2.pc", pc, 32'h100);
    chk("rst2.mis", {31'h0, misalign}, 32'h0);
    tick(); imem_rdy = 1'b0;
    look("to.start", 1'b1, 32'h100, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 254; i++) tick();
    #2;
    chk("to.254", {31'h0, imem_timeout}, 32'h0);
    chk("to.addr", imem_addr, 32'h100);
    tick(); #2;
    chk("to.255", {31'h0, imem_timeout}, 32'h1);
    imem_rdy = 1'b1;
    tick(); #2;
    chk("to.sticky", {31'h0, imem_timeout}, 32'h1);
    chk("to.pc", pc, 32'h104);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Instruction-fetch stage of the five-stage Minisys pipeline. Owns the program counter, selects the next PC from the decode-stage redirect (`pcsource`), runs the request/ready handshake to instruction memory, and feeds `pc4`/`ins`/`wir` into the IF/ID pipeline register. It absorbs memory wait states and decode stalls, and discards wrong-path words after a redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded at reset.
- `WAIT_LIMIT`, 255, consecutive wait cycles before `imem_timeout` is flagged (8-bit counter).

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `clrn` in 1: synchronous, active-low reset.
- `pcsource` in 2: next-PC select from decode. 00 = sequential, 01 = `bpc`, 10 = `rpc`, 11 = `jpc`.
- `bpc`, `rpc`, `jpc` in 32: branch, register-jump and jump targets.
- `stall` in 1: decode hazard; IF/ID must hold.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_rdy` in 1: read data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `wir` out 1: IF/ID load enable.
- `pc4` out 32: PC+4 of the delivered word; 0 for a bubble.
- `ins` out 32: delivered word; 32'h0 (NOP) for a bubble.
- `pc` out 32: current fetch PC.
- `imem_timeout` out 1: sticky wait-limit flag.
- `misalign` out 1: sticky misaligned-target flag; only present with the macro, otherwise tied 0.

## Operation
- States: IDLE, FETCH, DRAIN, HOLD (plus HALT with the macro).
- Reset (`clrn`=0 at an edge): state=IDLE, `pc`=RESET_PC, hold buffer=0, target reg=0, timeout counter=0, `imem_timeout`=0, `misalign`=0.
- Outputs are combinational from state and inputs:
  - IDLE: `imem_req`=0, `wir`=0.
  - All other states: `wir`=~`stall`.
  - `imem_addr`=`pc` whenever `imem_req`=1.
- Target = mux(`pcsource`). A redirect is `pcsource`≠0 with `stall`=0. `stall`=1 masks `pcsource` entirely.
- IDLE: go to FETCH next cycle.
- FETCH (`imem_req`=1):
  - `stall`=1, `imem_rdy`: capture `imem_rdata` into the hold buffer; go to HOLD.
  - `stall`=1, !`imem_rdy`: wait.
  - Redirect, `imem_rdy`: bubble out; `pc`←target; stay in FETCH.
  - Redirect, !`imem_rdy`: bubble out; target reg←target; go to DRAIN.
  - Sequential, `imem_rdy`: `ins`=`imem_rdata`, `pc4`=`pc`+4, `pc`←`pc`+4.
  - Sequential, !`imem_rdy`: bubble out (`ins`=0, `pc4`=0).
- HOLD (`imem_req`=0):
  - `stall`=1: stay.
  - `stall`=0, no redirect: deliver the held word with `pc4`=`pc`+4; `pc`←`pc`+4; go to FETCH.
  - `stall`=0, redirect: bubble out; `pc`←target; go to FETCH.
- DRAIN (`imem_req`=1, `imem_addr`=old `pc`, which stays stable):
  - Output is a bubble whenever `wir`=1.
  - A further redirect overwrites the target reg (latest wins).
  - On `imem_rdy`: discard the data; `pc`←target reg (or the new target if redirecting in the same cycle); go to FETCH.
- Handshake: `imem_addr` must not change while `imem_req`=1 and `imem_rdy`=0. A request is never abandoned.
- Timeout counter:
  - Increments each cycle with `imem_req`=1 and `imem_rdy`=0; clears on `imem_rdy` or when `imem_req`=0; saturates at WAIT_LIMIT.
  - Reaching WAIT_LIMIT sets `imem_timeout` until reset. Fetch keeps waiting.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0, no flag.

## Timing
- First `imem_req` occurs in the second cycle after `clrn` rises (IDLE lasts one cycle).
- Zero-wait memory: one word delivered per cycle, so fetch latency is 0 cycles from `imem_rdy`.
- Redirect penalty: exactly one bubble when `imem_rdy`=1 in the redirect cycle. When not ready, bubbles continue until the stale request completes, and the target request is issued the cycle after that.
- Coming out of HOLD: the held word is delivered in the cycle `stall` falls; the next request is issued the following cycle.
- Reset mid-DRAIN or mid-HOLD: the pending word is dropped and the memory request is deasserted at the next edge. The memory must tolerate the abandoned request.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - Any PC load with bits [1:0]≠0 (target or RESET_PC) sets `misalign` and enters HALT.
  - HALT: `imem_req`=0, `wir`=~`stall`, bubbles only, exit by reset only.
- Undefined: bits [1:0] of every loaded PC are forced to 00; `misalign` is tied 0; HALT does not exist.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning addr as data → words 0x100, 0x104, 0x108 on consecutive cycles with `pc4`=0x104, 0x108, 0x10C.
- `pcsource`=01, `bpc`=0x200, `imem_rdy`=1 → one NOP bubble with `wir`=1, then next request at 0x200.
- `pcsource`=11, `jpc`=0x300 while `imem_rdy`=0 for 3 cycles → `imem_addr` holds the old PC, 4 bubbles, data discarded, then request at 0x300.
- `stall`=1 for 4 cycles with data ready → `wir`=0, `imem_req`=0 after capture; on release the held word is delivered once, with no duplicate and no skip.
- `imem_rdy` held low for 255 cycles → `imem_timeout` rises at cycle 255 and stays 1 after `imem_rdy` returns.
- With the macro, `rpc`=0x403 redirect → `misalign`=1, `imem_req`=0, NOPs until reset. Without the macro → request at 0x400.
